// File: rtl/ram_write_traverse_pkg.sv
// Shared sizes, state encoding and the fill pattern for the RAM write/verify/display block.
package ram_write_traverse_pkg;

    localparam int CNT_MAX_DEF = 24_999_999;
    localparam int AW          = 5;
    localparam int DW          = 4;
    localparam int RD_LAT      = 2;
    localparam int CNT_W       = 26;
    localparam int DEPTH       = 1 << AW;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WRITE   = 2'd1,
        ST_VERIFY  = 2'd2,
        ST_DISPLAY = 2'd3
    } state_t;

    // Pattern repeats every 2^DW words because only the low address bits take part.
    function automatic logic [DW-1:0] pattern_word(input logic [DW-1:0] seed_v,
                                                   input logic [AW-1:0] a);
        return seed_v + a[DW-1:0];
    endfunction

endpackage

// File: rtl/ram_4x32.sv
// Behavioural stand-in for the single-port RAM IP: registered address/data/wren and registered q.
module ram_4x32
    import ram_write_traverse_pkg::*;
(
    input  logic          clock,
    input  logic [AW-1:0] address,
    input  logic [DW-1:0] data,
    input  logic          wren,
    output logic [DW-1:0] q
);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] addr_q;

    // Input register captures the address; output register adds the second read cycle.
    always_ff @(posedge clock) begin
        addr_q <= address;
        if (wren) begin
            mem[address] <= data;
        end
        q <= mem[addr_q];
    end

endmodule

// File: rtl/ram_write_traverse.sv
// Fills the RAM with a seeded pattern, reads it back and checks it, then steps through
// the stored words on active-low LEDs, one address per CNT_MAX+1 clocks.
module ram_write_traverse
    import ram_write_traverse_pkg::*;
#(
    parameter int CNT_MAX = CNT_MAX_DEF
)(
    input  logic          sclk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] seed,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [DW-1:0] n_data
);

    localparam logic [CNT_W-1:0] CNT_TC    = CNT_W'(CNT_MAX);
    localparam logic [CNT_W-1:0] VER_WORDS = CNT_W'(DEPTH);
    localparam logic [AW-1:0]    ADDR_LAST = AW'(DEPTH - 1);

    state_t             state_q, state_d;
    logic [AW-1:0]      addr_q, addr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]      seed_q, seed_d;
    logic               err_q, err_d;
    logic [DW-1:0]      n_data_q, n_data_d;
    logic               start_ok;

    logic [AW-1:0]      ram_addr;
    logic [DW-1:0]      ram_data;
    logic               ram_wren;
    logic [DW-1:0]      ram_q;

    logic               vld_p0, last_p0;
    logic [DW-1:0]      exp_p0;
    logic               vld_p1, last_p1;
    logic [DW-1:0]      exp_p1;
    logic               vld_p2, last_p2;
    logic [DW-1:0]      exp_p2;

    ram_4x32 u_ram (
        .clock   (sclk),
        .address (ram_addr),
        .data    (ram_data),
        .wren    (ram_wren),
        .q       (ram_q)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        seed_d   = seed_q;
        err_d    = err_q;
        ram_addr = addr_q;
        ram_data = pattern_word(seed_q, addr_q);
        ram_wren = 1'b0;
        vld_p0   = 1'b0;
        last_p0  = (addr_q == ADDR_LAST);
        exp_p0   = pattern_word(seed_q, addr_q);
        start_ok = start && ((state_q == ST_IDLE) || (state_q == ST_DISPLAY));

        case (state_q)
            ST_IDLE: begin
            end
            ST_WRITE: begin
                ram_wren = 1'b1;
                addr_d   = addr_q + 1'b1;
                if (addr_q == ADDR_LAST) begin
                    addr_d  = '0;
                    cnt_d   = '0;
                    state_d = ST_VERIFY;
                end
            end
            ST_VERIFY: begin
                // cnt tracks issued reads so the read side stops while the pipe drains.
                if (cnt_q < VER_WORDS) begin
                    vld_p0 = 1'b1;
                    addr_d = addr_q + 1'b1;
                    cnt_d  = cnt_q + 1'b1;
                end
                if (vld_p2 && (ram_q != exp_p2)) begin
                    err_d = 1'b1;
                end
                if (vld_p2 && last_p2) begin
                    addr_d  = '0;
                    cnt_d   = '0;
                    state_d = ST_DISPLAY;
                end
            end
            ST_DISPLAY: begin
                if (cnt_q == CNT_TC) begin
                    cnt_d  = '0;
                    addr_d = addr_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (start_ok) begin
            seed_d  = seed;
            err_d   = 1'b0;
            addr_d  = '0;
            cnt_d   = '0;
            state_d = ST_WRITE;
        end

        n_data_d = (state_q == ST_DISPLAY) ? ~ram_q : '1;
    end

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            cnt_q    <= '0;
            seed_q   <= '0;
            err_q    <= 1'b0;
            n_data_q <= '1;
            vld_p1   <= 1'b0;
            last_p1  <= 1'b0;
            vld_p2   <= 1'b0;
            last_p2  <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            seed_q   <= seed_d;
            err_q    <= err_d;
            n_data_q <= n_data_d;
            // p0 -> p1: read address registered inside the RAM
            vld_p1   <= vld_p0;
            last_p1  <= vld_p0 && last_p0;
            // p1 -> p2: aligned with the RAM q register
            vld_p2   <= vld_p1;
            last_p2  <= last_p1;
        end
    end

    // Expected-value pipeline carries data only; its valid bits above qualify it.
    always_ff @(posedge sclk) begin
        exp_p1 <= exp_p0;
        exp_p2 <= exp_p1;
    end

    assign busy   = (state_q == ST_WRITE) || (state_q == ST_VERIFY);
    assign done   = (state_q == ST_DISPLAY);
    assign err    = err_q;
    assign n_data = n_data_q;

endmodule

// File: tb/tb_ram_write_traverse.sv
// Directed bench for ram_write_traverse with a short display period.
module tb_ram_write_traverse;

    logic       sclk;
    logic       rst;
    logic       start;
    logic [3:0] seed;
    logic       busy;
    logic       done;
    logic       err;
    logic [3:0] n_data;

    int checks;
    int errors;
    logic [3:0] flip_v;

    ram_write_traverse #(.CNT_MAX(9)) dut (
        .sclk   (sclk),
        .rst    (rst),
        .start  (start),
        .seed   (seed),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .n_data (n_data)
    );

    initial begin
        sclk = 1'b0;
        forever #5 sclk = ~sclk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; seed = 4'h0;
        repeat (2) @(negedge sclk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || n_data !== 4'hF) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b err=%b n_data=%h expected 0 0 0 f",
                     busy, done, err, n_data);
        end
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge sclk);
            checks++;
            if (dut.ram_wren !== 1'b0 || busy !== 1'b0 || n_data !== 4'hF) begin
                errors++;
                $display("FAIL reset_idle_%0d: got wren=%b busy=%b n_data=%h expected 0 0 f",
                         i, dut.ram_wren, busy, n_data);
            end
        end
    endtask

    // Pulses start with seed s and checks the whole 32-write + 34-verify phase.
    task automatic run_fill(input logic [3:0] s, input bit inject);
        logic [3:0] e;
        seed = s; start = 1'b1;
        @(negedge sclk);
        start = 1'b0;
        for (int k = 0; k <= 66; k++) begin
            checks++;
            if (k < 66) begin
                if (busy !== 1'b1 || done !== 1'b0) begin
                    errors++;
                    $display("FAIL fill_busy_k%0d: got busy=%b done=%b expected 1 0", k, busy, done);
                end
            end else begin
                if (busy !== 1'b0 || done !== 1'b1 || err !== 1'b0) begin
                    errors++;
                    $display("FAIL fill_done: got busy=%b done=%b err=%b expected 0 1 0",
                             busy, done, err);
                end
            end
            checks++;
            if (k < 32) begin
                e = s + k[3:0];
                if (dut.ram_wren !== 1'b1 || dut.ram_addr !== k[4:0] || dut.ram_data !== e) begin
                    errors++;
                    $display("FAIL write_k%0d: got wren=%b addr=%0d data=%h expected 1 %0d %h",
                             k, dut.ram_wren, dut.ram_addr, dut.ram_data, k, e);
                end
            end else begin
                if (dut.ram_wren !== 1'b0) begin
                    errors++;
                    $display("FAIL wren_off_k%0d: got %b expected 0", k, dut.ram_wren);
                end
            end
            if (k == 0) begin
                checks++;
                if (err !== 1'b0) begin
                    errors++;
                    $display("FAIL err_cleared: got %b expected 0", err);
                end
            end
            if (inject && (k == 10 || k == 40)) begin
                seed = 4'h7; start = 1'b1;
            end else begin
                seed = s; start = 1'b0;
            end
            if (k < 66) @(negedge sclk);
        end
    endtask

    task automatic test_fill();
        run_fill(4'h3, 1'b0);
    endtask

    task automatic test_display();
        logic [3:0] e;
        repeat (5) @(negedge sclk);
        for (int a = 0; a <= 32; a++) begin
            e = ~(4'h3 + a[3:0]);
            checks++;
            if (n_data !== e) begin
                errors++;
                $display("FAIL display_word%0d: got %h expected %h", a, n_data, e);
            end
            if (a < 32) repeat (10) @(negedge sclk);
        end
    endtask

    task automatic test_start_ignored();
        run_fill(4'h3, 1'b1);
        repeat (5) @(negedge sclk);
        checks++;
        if (n_data !== 4'hC) begin
            errors++;
            $display("FAIL ignored_word0: got %h expected c", n_data);
        end
        repeat (10) @(negedge sclk);
        checks++;
        if (n_data !== 4'hB) begin
            errors++;
            $display("FAIL ignored_word1: got %h expected b", n_data);
        end
    endtask

    task automatic test_verify_fault();
        seed = 4'h5; start = 1'b1;
        @(negedge sclk);
        start = 1'b0;
        for (int k = 0; k <= 66; k++) begin
            if (k == 40) begin
                checks++;
                if (err !== 1'b0) begin
                    errors++;
                    $display("FAIL fault_pre_err: got %b expected 0", err);
                end
                flip_v = dut.ram_q ^ 4'h1;
                force dut.ram_q = flip_v;
            end
            if (k == 41) begin
                release dut.ram_q;
                checks++;
                if (err !== 1'b1) begin
                    errors++;
                    $display("FAIL fault_err_set: got %b expected 1", err);
                end
            end
            if (k == 66) begin
                checks++;
                if (done !== 1'b1 || busy !== 1'b0 || err !== 1'b1) begin
                    errors++;
                    $display("FAIL fault_done: got done=%b busy=%b err=%b expected 1 0 1",
                             done, busy, err);
                end
            end
            if (k < 66) @(negedge sclk);
        end
        repeat (5) @(negedge sclk);
        checks++;
        if (err !== 1'b1 || n_data !== 4'hA) begin
            errors++;
            $display("FAIL fault_sticky: got err=%b n_data=%h expected 1 a", err, n_data);
        end
    endtask

    task automatic test_restart();
        run_fill(4'hE, 1'b0);
        repeat (5) @(negedge sclk);
        checks++;
        if (n_data !== 4'h1) begin
            errors++;
            $display("FAIL restart_word0: got %h expected 1", n_data);
        end
        repeat (10) @(negedge sclk);
        checks++;
        if (n_data !== 4'h0) begin
            errors++;
            $display("FAIL restart_word1: got %h expected 0", n_data);
        end
        repeat (10) @(negedge sclk);
        checks++;
        if (n_data !== 4'hF) begin
            errors++;
            $display("FAIL restart_word2: got %h expected f", n_data);
        end
    endtask

    task automatic test_reset_mid();
        #2 rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || n_data !== 4'hF) begin
            errors++;
            $display("FAIL async_reset_display: got busy=%b done=%b err=%b n_data=%h expected 0 0 0 f",
                     busy, done, err, n_data);
        end
        @(negedge sclk);
        rst = 1'b0;
        seed = 4'h9; start = 1'b1;
        @(negedge sclk);
        start = 1'b0;
        repeat (20) @(negedge sclk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL midwrite_busy: got %b expected 1", busy);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || n_data !== 4'hF || dut.ram_wren !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_write: got busy=%b done=%b n_data=%h wren=%b expected 0 0 f 0",
                     busy, done, n_data, dut.ram_wren);
        end
        @(negedge sclk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge sclk);
            checks++;
            if (dut.ram_wren !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_idle_%0d: got wren=%b busy=%b expected 0 0",
                         i, dut.ram_wren, busy);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_fill();
        test_display();
        test_start_ignored();
        test_verify_fault();
        test_restart();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_write_traverse.md
Name: ram_write_traverse

Overview:
Writer-side counterpart of the periodic ROM-address traversal display. The block fills a 32-word x 4-bit single-port on-chip RAM with a seeded pattern, then reads every word back at full clock rate and checks it. It then cycles through the stored words, one address per 500 ms, and drives the read data onto active-low LEDs. It sits between the board buttons/LEDs and the ram_4x32 memory instance.

Parameters:
CNT_MAX, 24_999_999, display-step terminal count; the address advances every CNT_MAX+1 sclk cycles (500 ms at 50 MHz).
AW, 5, RAM address width; depth is 2^AW = 32.
DW, 4, RAM data width.
RD_LAT, 2, RAM read latency in cycles (registered address plus registered q).

Ports:
sclk     input   1    system clock, 50 MHz
rst      input   1    asynchronous reset, active-high
start    input   1    single-cycle pulse; begins fill/verify/display; honoured only in IDLE or DISPLAY
seed     input   DW   pattern seed; sampled on the accepted start
busy     output  1    high during WRITE and VERIFY
done     output  1    high in DISPLAY; cleared on an accepted start
err      output  1    sticky: set on any verify mismatch; cleared on an accepted start
n_data   output  DW   active-low LED drive = ~(RAM word at the current display address)

Behaviour:
- Reset (async, rst=1): state IDLE, addr=0, cnt=0, seed_q=0, busy=0, done=0, err=0, n_data=4'hF (LEDs off), wren=0.
- Pattern: expected(a) = (seed_q + a[DW-1:0]) mod 2^DW, so the 4-bit pattern repeats twice over 32 words.
- IDLE: outputs hold their reset values.
  - start=1 -> seed_q<=seed, err<=0, done<=0, addr<=0, go to WRITE.
- WRITE: each cycle, wren=1, address=addr, data=expected(addr).
  - addr increments every cycle.
  - After the write to addr=31: wren=0, addr<=0, go to VERIFY.
  - Exactly 32 write cycles; busy=1 throughout.
- VERIFY: the read address steps 0..31, one per cycle.
  - The expected value and a valid bit are delayed RD_LAT cycles alongside the read to align with q.
  - When the delayed valid is high and q != delayed expected: err<=1. err is sticky.
  - After the last aligned compare (address 31 plus RD_LAT cycles): addr<=0, cnt<=0, go to DISPLAY. Phase length is 32+RD_LAT cycles.
- DISPLAY: busy=0, done=1.
  - cnt counts 0..CNT_MAX, then wraps to 0.
  - On cnt==CNT_MAX, addr<=addr+1; 31 wraps to 0.
  - n_data is registered: ~q, continuously updated.
  - After an address change, the new word appears on n_data RD_LAT+1 cycles later.
- start in DISPLAY: restarts exactly as from IDLE (new seed, err cleared).
- start during WRITE or VERIFY: ignored, no side effects.
- wren is never asserted outside WRITE. No read-modify-write.
- Reset mid-WRITE or mid-VERIFY: immediate return to IDLE with reset outputs. RAM contents are undefined afterward and are not relied on.
- Arithmetic: all additions wrap modulo their width (AW for addr, DW for pattern). cnt is 26 bits.

Decomposition:
- Shared package/header: CNT_MAX default, AW, DW, RD_LAT, state encoding (IDLE=0, WRITE=1, VERIFY=2, DISPLAY=3).
- One sub-module: ram_4x32.
  - Quartus single-port RAM IP; ports clock, address[4:0], data[3:0], wren, q[3:0].
  - Registered input and output, hence RD_LAT=2.
- The FSM, counters and compare pipeline stay in the top module.

Test Plan:
- Reset: assert rst mid-run -> n_data=4'hF, busy=0, done=0, err=0 within the same cycle (async). No wren after release until start.
- Fill: CNT_MAX=9, seed=4'h3, pulse start -> busy high 32+34 cycles. Write data sequence 3,4,...,F,0,1,2,3,... (word 13 = 0). Then done=1, err=0.
- Display stepping: after done with seed=4'h3 -> n_data=~4'h3=4'hC. Every 10 cycles the next word shows (4'hB, 4'hA...). After 32 steps addr wraps to 0 and n_data=4'hC again.
- Verify fault: force q bit0 flipped for one aligned cycle during VERIFY -> err=1, and it stays 1 into DISPLAY.
- Start ignored: pulse start with seed=4'h7 during WRITE -> pattern still seed 3, phase lengths unchanged.
- Restart from DISPLAY: seed=4'hE, pulse start -> err cleared, done=0, refill; word 0 later displays n_data=~4'hE=4'h1; word 2 = 4'h0 wraps correctly.
